adc_frame_capture: RTL and testbench
====================================

// Module: adc_frame_capture
// PURPOSE
//  Front end of top: drives the 8-bit ADC sample clock AD0_CLK from 50 MHz clk via a phase accumulator (NCO),
//  registers AD0 and converts offset-binary to signed, then captures a FRAME_LEN-sample frame into on-chip RAM.
//  Streams the frame to the downstream spectrum/separation stage over a valid/ready interface, with frame min/max.
// PARAMETERS
//  DW        8           ADC sample width
//  ACC_W     32          phase accumulator width
//  FTW       439804651   tuning word; f_AD0_CLK = 50e6*FTW/2^ACC_W = 5.12 MHz
//  FRAME_LEN 1024        samples per frame
//  ADDR_W    10          RAM address width, = clog2(FRAME_LEN)
// PORTS
//  clk         in   1       50 MHz system clock
//  reset       in   1       synchronous, active-high reset
//  AD0         in   DW      ADC data, offset binary (0x80 = mid-scale)
//  AD0_CLK     out  1       ADC sample clock = accumulator MSB, registered
//  start       in   1       one-cycle pulse: arm a frame capture
//  busy        out  1       high in any state other than IDLE
//  frame_done  out  1       high while a complete frame awaits or is being read out (READY, READOUT)
//  m_data      out  DW      signed sample, two's complement
//  m_valid     out  1       m_data valid
//  m_ready     in   1       downstream accept
//  m_last      out  1       with m_valid: sample index FRAME_LEN-1
//  frame_max   out  DW      signed max of last captured frame
//  frame_min   out  DW      signed min of last captured frame
// BEHAVIOUR
//  Reset: acc=0, AD0_CLK=0, state=IDLE, busy=0, frame_done=0, m_valid=0, m_last=0, m_data=0,
//   frame_max=-2^(DW-1), frame_min=2^(DW-1)-1.
//  NCO: acc <= acc+FTW every clk, wraps mod 2^ACC_W; AD0_CLK <= acc[ACC_W-1]. Runs in all states.
//  Capture: ad_q <= AD0 every clk. sample_stb asserts for one clk on each AD0_CLK 1->0 transition.
//   The ADC data is mid-period there. sample_s = {~ad_q[DW-1], ad_q[DW-2:0]}.
//  FSM:
//   IDLE     start=1 -> ALIGN; start ignored in every other state (no queuing).
//   ALIGN    clears run min/max; on first sample_stb writes RAM[0], wr_addr=1 -> FILL.
//   FILL     each sample_stb writes RAM[wr_addr] and updates run min/max.
//            After the write at FRAME_LEN-1 -> READY, latch frame_max/min.
//   READY    rd_addr=0, issue RAM read -> READOUT.
//   READOUT  RAM read latency 1 clk. First m_valid 2 clks after READY is entered.
//            m_data/m_valid/m_last stay stable while m_valid & !m_ready.
//            Each m_valid&m_ready advances index. Pipeline uses a 1-entry prefetch/skid, so an
//            always-ready sink gets one sample per clk. Transfer with m_last -> IDLE (m_valid=0 next clk).
//  No sample is written outside ALIGN/FILL, so no overrun. Frame samples are consecutive sample_stb events.
//  Reset asserted in any state: next clk is the reset state; partial frame discarded, frame_max/min reset.
//  Simultaneous start and reset: reset wins.
// STRUCTURE
//  Package adc_cap_pkg: DW, ACC_W, FTW_5M12 localparam, FRAME_LEN default, state enum
//   (IDLE, ALIGN, FILL, READY, READOUT) as localparams.
//  Sub-module sdp_ram #(DW, ADDR_W): simple dual-port, 1 write port, 1 registered read port, same clk.
//  NCO, strobe, conversion, FSM, min/max and stream register in this module.
// TESTING
//  1 Reset: hold reset 5 clks -> all outputs at reset values; AD0_CLK toggles starting after release.
//  2 Rate: run 50000 clks -> exactly 5120 +/-1 sample_stb pulses; AD0_CLK high time 4 or 5 of 9-10 clks.
//  3 Conversion/min-max: ADC model sets AD0=0x80, 0xFF, 0x00, 0x41 repeating on AD0_CLK rising edge,
//    then one frame -> m_data 0, 127, -128, -63 cyclic; frame_max=127, frame_min=-128.
//  4 Ramp frame: AD0 = sample index mod 256, m_ready=1 -> 1024 beats, one per clk, data matches,
//    m_last only on beat 1023, busy drops 1 clk after it.
//  5 Backpressure: m_ready random 30% duty -> no beat lost, duplicated or changed while stalled; same sequence as 4.
//  6 Abuse: start pulsed during FILL and READOUT -> ignored.
//    Reset at FILL sample 500 -> IDLE; new start captures a full fresh 1024-sample frame.

Source files
------------

// File: rtl/adc_cap_pkg.sv
// Shared constants and state encoding for the ADC frame capture front end.
package adc_cap_pkg;
    localparam int DW        = 8;
    localparam int ACC_W     = 32;
    localparam int FRAME_LEN = 1024;
    localparam logic [ACC_W-1:0] FTW_5M12 = 32'd439804651;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ALIGN   = 3'd1,
        FILL    = 3'd2,
        READY   = 3'd3,
        READOUT = 3'd4
    } state_t;
endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module sdp_ram #(
    parameter int DW     = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DW-1:0]     wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DW-1:0]     rdata
);
    logic [DW-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/adc_frame_capture.sv
// ADC sample clock NCO, sample capture into a frame RAM, and valid/ready frame readout with min/max.
// state   | meaning
// IDLE    | waiting for start
// ALIGN   | armed, first sample goes to RAM[0]
// FILL    | writing samples 1..FRAME_LEN-1
// READY   | frame complete, first RAM read issued
// READOUT | streaming frame to the sink
module adc_frame_capture #(
    parameter int                 DW        = adc_cap_pkg::DW,
    parameter int                 ACC_W     = adc_cap_pkg::ACC_W,
    parameter logic [ACC_W-1:0]   FTW       = adc_cap_pkg::FTW_5M12,
    parameter int                 FRAME_LEN = adc_cap_pkg::FRAME_LEN,
    parameter int                 ADDR_W    = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] AD0,
    output logic          AD0_CLK,
    input  logic          start,
    output logic          busy,
    output logic          frame_done,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic [DW-1:0] frame_max,
    output logic [DW-1:0] frame_min
);
    import adc_cap_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W:0]   LEN_CNT   = (ADDR_W + 1)'(FRAME_LEN);
    localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W + 1)'(FRAME_LEN - 1);
    localparam logic [DW-1:0]     SMAX      = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]     SMIN      = {1'b1, {(DW-1){1'b0}}};

    state_t                state, state_nx;
    logic [ACC_W-1:0]      acc;
    logic                  clk_q;
    logic [DW-1:0]         ad_q;
    logic                  sample_stb;
    logic signed [DW-1:0]  sample_s;
    logic [ADDR_W-1:0]     wr_addr;
    logic [ADDR_W-1:0]     waddr;
    logic                  we;
    logic signed [DW-1:0]  run_max, run_min, nx_max, nx_min;
    logic [ADDR_W:0]       rd_cnt;
    logic                  re;
    logic [DW-1:0]         rdata;
    logic                  rd_infl, rd_infl_last;
    logic                  sk_valid, sk_last;
    logic [DW-1:0]         sk_data;
    logic                  pop, keep_out;
    logic [1:0]            occ;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            AD0_CLK <= 1'b0;
            clk_q   <= 1'b0;
        end else begin
            acc     <= acc + FTW;
            AD0_CLK <= acc[ACC_W-1];
            clk_q   <= AD0_CLK;
        end
    end

    // Falling edge of AD0_CLK lands mid-way through the ADC data-valid window.
    always_ff @(posedge clk) ad_q <= AD0;
    assign sample_stb = clk_q & ~AD0_CLK;
    assign sample_s   = {~ad_q[DW-1], ad_q[DW-2:0]};

    assign nx_max = (sample_s > run_max) ? sample_s : run_max;
    assign nx_min = (sample_s < run_min) ? sample_s : run_min;

    assign pop      = m_valid & m_ready;
    assign keep_out = m_valid & ~m_ready;
    // Entries held in output + skid after this edge, before any new read lands.
    assign occ      = 2'(keep_out) + 2'(sk_valid) + 2'(rd_infl);
    assign waddr    = (state == ALIGN) ? '0 : wr_addr;

    always_comb begin
        state_nx = state;
        we       = 1'b0;
        re       = 1'b0;
        unique case (state)
            IDLE:    if (start) state_nx = ALIGN;
            ALIGN:   if (sample_stb) begin
                         we       = 1'b1;
                         state_nx = FILL;
                     end
            FILL:    if (sample_stb) begin
                         we = 1'b1;
                         if (wr_addr == LAST_ADDR) state_nx = READY;
                     end
            READY:   begin
                         re       = 1'b1;
                         state_nx = READOUT;
                     end
            READOUT: begin
                         re = (rd_cnt != LEN_CNT) && (occ < 2'd2);
                         if (pop && m_last) state_nx = IDLE;
                     end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wr_addr      <= '0;
            run_max      <= SMIN;
            run_min      <= SMAX;
            frame_max    <= SMIN;
            frame_min    <= SMAX;
            rd_cnt       <= '0;
            rd_infl      <= 1'b0;
            rd_infl_last <= 1'b0;
            sk_valid     <= 1'b0;
            sk_last      <= 1'b0;
            sk_data      <= '0;
            m_valid      <= 1'b0;
            m_last       <= 1'b0;
            m_data       <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ALIGN: begin
                    rd_cnt <= '0;
                    if (sample_stb) begin
                        wr_addr <= ADDR_W'(1);
                        run_max <= sample_s;
                        run_min <= sample_s;
                    end else begin
                        run_max <= SMIN;
                        run_min <= SMAX;
                    end
                end
                FILL: if (sample_stb) begin
                    wr_addr <= wr_addr + ADDR_W'(1);
                    run_max <= nx_max;
                    run_min <= nx_min;
                    if (wr_addr == LAST_ADDR) begin
                        frame_max <= nx_max;
                        frame_min <= nx_min;
                    end
                end
                default: ;
            endcase

            if (re) rd_cnt <= rd_cnt + (ADDR_W + 1)'(1);
            rd_infl      <= re;
            rd_infl_last <= re && (rd_cnt == LAST_CNT);

            // Ordered pipeline: output register, then skid, then the read in flight.
            if (state == READOUT && pop && m_last) begin
                m_valid  <= 1'b0;
                m_last   <= 1'b0;
                sk_valid <= 1'b0;
                rd_infl  <= 1'b0;
            end else if (keep_out) begin
                if (!sk_valid) begin
                    sk_valid <= rd_infl;
                    sk_last  <= rd_infl_last;
                    sk_data  <= rdata;
                end
            end else if (sk_valid) begin
                m_valid  <= 1'b1;
                m_data   <= sk_data;
                m_last   <= sk_last;
                sk_valid <= rd_infl;
                sk_last  <= rd_infl_last;
                sk_data  <= rdata;
            end else begin
                m_valid <= rd_infl;
                m_last  <= rd_infl & rd_infl_last;
                if (rd_infl) m_data <= rdata;
            end
        end
    end

    assign busy       = (state != IDLE);
    assign frame_done = (state == READY) || (state == READOUT);

    sdp_ram #(.DW(DW), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (sample_s),
        .re    (re),
        .raddr (rd_cnt[ADDR_W-1:0]),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_adc_frame_capture.sv
// Bench for adc_frame_capture: behavioural NCO/frame model checked every cycle, plus literal pins.
module tb_adc_frame_capture;
    localparam int N = 1024;
    localparam longint unsigned FTW = 64'd439804651;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       m_ready = 1'b0;
    logic [7:0] AD0 = 8'h80;
    logic       AD0_CLK, busy, frame_done, m_valid, m_last;
    logic [7:0] m_data, frame_max, frame_min;

    adc_frame_capture dut (
        .clk        (clk),
        .reset      (reset),
        .AD0        (AD0),
        .AD0_CLK    (AD0_CLK),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .frame_max  (frame_max),
        .frame_min  (frame_min)
    );

    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ---------------- ADC model: new value on each AD0_CLK rising edge ----------------
    logic [7:0] cyc4 [4] = '{8'h80, 8'hFF, 8'h00, 8'h41};
    int   pat_mode = 0;
    int   pat_idx  = 0;
    logic prev_adclk = 1'b0;

    always @(posedge clk) begin
        #1;
        if (AD0_CLK && !prev_adclk) begin
            if (pat_mode == 0) AD0 = cyc4[pat_idx % 4];
            else               AD0 = 8'(pat_idx);
            pat_idx++;
        end
        prev_adclk = AD0_CLK;
    end

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 collecting a frame, 2 frame held / streaming out
    longint unsigned m_acc = 0;
    bit     m_clk = 0, m_clk_q = 0;
    logic [7:0] m_adq = 8'h00;
    int     mode = 0;
    int     frame [N];
    int     got [N];
    int     cap_cnt = 0, beat = 0;
    int     exp_max = -128, exp_min = 127;
    longint cyc = 0, comp_cyc = 0, t_first = 0, last_cyc = 0;
    bit     stall_prev = 0;

    always @(negedge clk) begin
        bit stb;
        cyc++;
        check("ad0_clk", AD0_CLK, m_clk);
        check("busy", busy, mode != 0);
        check("frame_done", frame_done, mode == 2);
        check("frame_max", $signed(frame_max), exp_max);
        check("frame_min", $signed(frame_min), exp_min);
        if (mode != 2 || cyc < comp_cyc + 3) check("m_valid_quiet", m_valid, 0);
        else if (cyc == comp_cyc + 3)        check("first_valid_latency", m_valid, 1);
        if (stall_prev) check("stall_hold_valid", m_valid, 1);
        if (m_valid === 1'b1 && mode == 2 && beat < N) begin
            check("m_data", $signed(m_data), frame[beat]);
            check("m_last", m_last, beat == N - 1);
        end
        stall_prev = (m_valid === 1'b1) && m_ready;
        stall_prev = (m_valid === 1'b1) && !m_ready;

        stb = m_clk_q && !m_clk;
        if (reset) begin
            m_acc = 0; m_clk = 0; m_clk_q = 0;
            mode = 0; cap_cnt = 0; beat = 0;
            exp_max = -128; exp_min = 127;
            stall_prev = 0;
        end else begin
            if (mode == 1 && stb) begin
                frame[cap_cnt] = int'(m_adq) - 128;
                cap_cnt++;
                if (cap_cnt == N) begin
                    mode = 2; comp_cyc = cyc; t_first = cyc + 3; beat = 0;
                    exp_max = -1000; exp_min = 1000;
                    for (int i = 0; i < N; i++) begin
                        if (frame[i] > exp_max) exp_max = frame[i];
                        if (frame[i] < exp_min) exp_min = frame[i];
                    end
                end
            end else if (mode == 2 && m_valid === 1'b1 && m_ready) begin
                got[beat] = $signed(m_data);
                if (beat == N - 1) begin
                    mode = 0; last_cyc = cyc;
                end
                beat++;
            end else if (mode == 0 && start) begin
                mode = 1; cap_cnt = 0;
            end
            m_clk_q = m_clk;
            m_clk   = m_acc[31];
            m_acc   = (m_acc + FTW) & 64'hFFFF_FFFF;
        end
        m_adq = AD0;
    end

    // ---------------- AD0_CLK rate / duty over 50000 clks after first release ----------------
    int  rel = 0, falls = 0, hi_len = 0, per = 0;
    bit  seen_rise = 0, rate_done = 0;
    logic prev_rate = 1'b0;

    always @(negedge clk) begin
        if (!rate_done) begin
            if (reset) begin
                rel = 0; falls = 0; hi_len = 0; per = 0; seen_rise = 0; prev_rate = 1'b0;
            end else begin
                rel++;
                if (AD0_CLK && !prev_rate) begin
                    if (seen_rise) check_range("ad0_clk_period", per, 9, 10);
                    seen_rise = 1; per = 0;
                end
                if (!AD0_CLK && prev_rate) begin
                    falls++;
                    check_range("ad0_clk_high", hi_len, 4, 5);
                    hi_len = 0;
                end
                if (AD0_CLK) hi_len++;
                per++;
                prev_rate = AD0_CLK;
                if (rel == 50000) begin
                    check_range("stb_count_50k", falls, 5119, 5121);
                    rate_done = 1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_frame(input int pm, input bit bp, input bit abuse, input int reset_at);
        bit p_fill = 0, p_rd = 0, done = 0;
        pat_mode = pm;
        pat_idx  = 0;
        m_ready  = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 40000 && !done; i++) begin
            start = 1'b0;
            if (reset_at > 0 && mode == 1 && cap_cnt == reset_at) begin
                reset = 1'b1;
                @(posedge clk); #1 reset = 1'b0;
                done = 1;
            end else begin
                if (abuse && mode == 1 && cap_cnt == 100 && !p_fill) begin
                    start = 1'b1; p_fill = 1;
                end
                if (abuse && mode == 2 && beat == 300 && !p_rd) begin
                    start = 1'b1; p_rd = 1;
                end
                m_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
                @(posedge clk); #1;
                if (!busy) done = 1;
            end
        end
        start   = 1'b0;
        m_ready = 1'b1;
        if (!done) begin
            checks++; errors++;
            $display("FAIL frame_timeout: got busy=%0d expected 0 within 40000 clks", busy);
        end
    endtask

    function automatic int next_cyc4(input int v);
        case (v)
            0:       return 127;
            127:     return -128;
            -128:    return -63;
            -63:     return 0;
            default: return 999;
        endcase
    endfunction

    initial begin
        #(20 * 99000);
        $display("FAIL watchdog: simulation exceeded 99000 clks");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset held 5 clks
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_m_data", m_data, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_ad0_clk", AD0_CLK, 0);
        check("rst_frame_max", $signed(frame_max), -128);
        check("rst_frame_min", $signed(frame_min), 127);
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(posedge clk);

        // 3: conversion and min/max with 0x80,0xFF,0x00,0x41
        run_frame(0, 0, 0, 0);
        check("t3_beats", beat, N);
        check("t3_frame_max", $signed(frame_max), 127);
        check("t3_frame_min", $signed(frame_min), -128);
        for (int i = 0; i < 4; i++) check("t3_seq", got[i + 1], next_cyc4(got[i]));
        check("t3_seq_tail", got[N - 1], next_cyc4(got[N - 2]));

        // 4: ramp, always-ready sink
        run_frame(1, 0, 0, 0);
        check("t4_beats", beat, N);
        check("t4_throughput", last_cyc - t_first, N - 1);
        check("t4_frame_max", $signed(frame_max), 127);
        check("t4_frame_min", $signed(frame_min), -128);
        for (int i = 0; i < N - 1; i += 255)
            check("t4_ramp", got[i + 1], (got[i] == 127) ? -128 : got[i] + 1);

        // 5: ramp with 30% ready, start pulsed during FILL and READOUT
        run_frame(1, 1, 1, 0);
        check("t5_beats", beat, N);
        check("t5_frame_max", $signed(frame_max), 127);
        check("t5_frame_min", $signed(frame_min), -128);
        for (int i = 1; i < N - 1; i += 300)
            check("t5_ramp", got[i + 1], (got[i] == 127) ? -128 : got[i] + 1);

        for (int i = 0; i < 60000 && !rate_done; i++) @(negedge clk);
        if (!rate_done) begin
            checks++; errors++;
            $display("FAIL rate_window: got rel=%0d expected 50000", rel);
        end

        // 6: start during FILL ignored, reset at sample 500, then a fresh frame
        run_frame(1, 0, 1, 500);
        @(negedge clk);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_frame_max", $signed(frame_max), -128);
        check("t6_rst_frame_min", $signed(frame_min), 127);
        repeat (5) @(posedge clk);
        #1;
        run_frame(1, 0, 0, 0);
        check("t6_beats", beat, N);
        check("t6_frame_max", $signed(frame_max), 127);
        check("t6_frame_min", $signed(frame_min), -128);
        check("t6_throughput", last_cyc - t_first, N - 1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
